// File: rtl/w0rm_core_writeback.sv
// W0RM core writeback stage: ALU/load result arbitration, registered register-file write pulse,
// and pending-write scoreboard for decode. Optional W0RM_WB_FORWARD_EN adds a 0-cycle bypass port.
module w0rm_core_writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 16,
    localparam int REG_ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic                     alu_write,
    input  logic [REG_ADDR_BITS-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     issue_valid,
    input  logic                     issue_mem,
    input  logic [REG_ADDR_BITS-1:0] issue_addr,
    output logic                     port_write_enable,
    output logic [REG_ADDR_BITS-1:0] port_write_addr,
    output logic [DATA_WIDTH-1:0]    port_write_data,
    output logic [NUM_REGISTERS-1:0] reg_pending
`ifdef W0RM_WB_FORWARD_EN
    ,
    output logic                     fwd_valid,
    output logic [REG_ADDR_BITS-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0]    fwd_data
`endif
);

    logic                     last_grant_alu_reg;
    logic                     last_grant_alu_next;
    logic [NUM_REGISTERS-1:0] pending_alu_reg;
    logic [NUM_REGISTERS-1:0] pending_alu_next;
    logic [NUM_REGISTERS-1:0] pending_mem_reg;
    logic [NUM_REGISTERS-1:0] pending_mem_next;
    logic                     wr_en_reg;
    logic                     wr_en_next;
    logic [REG_ADDR_BITS-1:0] wr_addr_reg;
    logic [REG_ADDR_BITS-1:0] wr_addr_next;
    logic [DATA_WIDTH-1:0]    wr_data_reg;
    logic [DATA_WIDTH-1:0]    wr_data_next;

    logic alu_req;
    logic conflict;
    logic grant_alu;
    logic grant_mem;
    logic alu_wr;
    logic issue_alu_set;
    logic issue_mem_set;

    // A flushed ALU result never competes: it is swallowed, so MEM sees an empty arbiter.
    assign alu_req   = alu_valid & ~flush;
    assign conflict  = alu_req & mem_valid;
    assign grant_alu = alu_req & (~mem_valid | ~last_grant_alu_reg);
    assign grant_mem = mem_valid & (~alu_req | last_grant_alu_reg);
    assign alu_ready = grant_alu | flush;
    assign mem_ready = grant_mem;
    assign alu_wr    = grant_alu & alu_write;

    assign issue_alu_set = issue_valid & ~flush & ~issue_mem;
    assign issue_mem_set = issue_valid & ~flush & issue_mem;

    always_comb begin
        last_grant_alu_next = last_grant_alu_reg;
        if (conflict) begin
            last_grant_alu_next = grant_alu;
        end
        wr_en_next   = alu_wr | grant_mem;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        if (grant_mem) begin
            wr_addr_next = mem_addr;
            wr_data_next = mem_data;
        end else if (alu_wr) begin
            wr_addr_next = alu_addr;
            wr_data_next = alu_data;
        end
    end

    // Per-register scoreboard bits; a new producer (set) overrides a retiring write (clear).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGISTERS; gi++) begin : g_pending
            logic alu_set;
            logic alu_clr;
            logic mem_set;
            logic mem_clr;

            assign alu_set = issue_alu_set && (issue_addr == REG_ADDR_BITS'(gi));
            assign mem_set = issue_mem_set && (issue_addr == REG_ADDR_BITS'(gi));
            assign alu_clr = alu_wr && (alu_addr == REG_ADDR_BITS'(gi));
            assign mem_clr = grant_mem && (mem_addr == REG_ADDR_BITS'(gi));

            assign pending_alu_next[gi] = flush ? 1'b0
                                        : (alu_set | (pending_alu_reg[gi] & ~alu_clr));
            assign pending_mem_next[gi] = mem_set | (pending_mem_reg[gi] & ~mem_clr);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_alu_reg <= 1'b1;
            pending_alu_reg    <= '0;
            pending_mem_reg    <= '0;
            wr_en_reg          <= 1'b0;
            wr_addr_reg        <= '0;
            wr_data_reg        <= '0;
        end else begin
            last_grant_alu_reg <= last_grant_alu_next;
            pending_alu_reg    <= pending_alu_next;
            pending_mem_reg    <= pending_mem_next;
            wr_en_reg          <= wr_en_next;
            wr_addr_reg        <= wr_addr_next;
            wr_data_reg        <= wr_data_next;
        end
    end

    assign port_write_enable = wr_en_reg;
    assign port_write_addr   = wr_addr_reg;
    assign port_write_data   = wr_data_reg;
    assign reg_pending       = pending_alu_reg | pending_mem_reg;

`ifdef W0RM_WB_FORWARD_EN
    assign fwd_valid = grant_mem | alu_wr;
    assign fwd_addr  = grant_mem ? mem_addr : alu_addr;
    assign fwd_data  = grant_mem ? mem_data : alu_data;
`endif

endmodule

// File: tb/tb_w0rm_core_writeback.sv
// Directed self-checking bench for w0rm_core_writeback; inputs change 1ns after the rising
// edge, outputs are sampled at the falling edge. Define W0RM_WB_FORWARD_EN to exercise the bypass.
module tb_w0rm_core_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic        alu_write;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic        issue_mem;
    logic [3:0]  issue_addr;
    logic        port_write_enable;
    logic [3:0]  port_write_addr;
    logic [31:0] port_write_data;
    logic [15:0] reg_pending;
`ifdef W0RM_WB_FORWARD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    w0rm_core_writeback #(.DATA_WIDTH(32), .NUM_REGISTERS(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush             (flush),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_write         (alu_write),
        .alu_addr          (alu_addr),
        .alu_data          (alu_data),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .issue_valid       (issue_valid),
        .issue_mem         (issue_mem),
        .issue_addr        (issue_addr),
        .port_write_enable (port_write_enable),
        .port_write_addr   (port_write_addr),
        .port_write_data   (port_write_data),
        .reg_pending       (reg_pending)
`ifdef W0RM_WB_FORWARD_EN
        ,
        .fwd_valid         (fwd_valid),
        .fwd_addr          (fwd_addr),
        .fwd_data          (fwd_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        alu_valid   = 1'b0;
        alu_write   = 1'b0;
        alu_addr    = 4'd0;
        alu_data    = 32'd0;
        mem_valid   = 1'b0;
        mem_addr    = 4'd0;
        mem_data    = 32'd0;
        issue_valid = 1'b0;
        issue_mem   = 1'b0;
        issue_addr  = 4'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #4;
        check_count++; if (port_write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", port_write_enable); else pass_count++;
        check_count++; if (port_write_addr !== 4'd0) $display("FAIL reset_addr: got %0d want 0", port_write_addr); else pass_count++;
        check_count++; if (port_write_data !== 32'd0) $display("FAIL reset_data: got %h want 0", port_write_data); else pass_count++;
        check_count++; if (reg_pending !== 16'h0000) $display("FAIL reset_pending: got %h want 0000", reg_pending); else pass_count++;
        check_count++; if ({alu_ready, mem_ready} !== 2'b00) $display("FAIL reset_ready_idle: got %b want 00", {alu_ready, mem_ready}); else pass_count++;
        alu_valid = 1'b1;
        #1;
        check_count++; if (alu_ready !== 1'b1) $display("FAIL reset_ready_comb: got %b want 1", alu_ready); else pass_count++;
        alu_valid = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        $display("txn reset: outputs cleared, ready follows arbiter");
    endtask

    task automatic test_alu_only();
        step();
        alu_valid = 1'b1; alu_write = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
        #4;
        check_count++; if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL alu_only_ready: got %b want 10", {alu_ready, mem_ready}); else pass_count++;
        check_count++; if (port_write_enable !== 1'b0) $display("FAIL alu_only_pre_we: got %b want 0", port_write_enable); else pass_count++;
        step();
        alu_valid = 1'b0;
        #4;
        check_count++; if (port_write_enable !== 1'b1) $display("FAIL alu_only_we: got %b want 1", port_write_enable); else pass_count++;
        check_count++; if (port_write_addr !== 4'd3) $display("FAIL alu_only_addr: got %0d want 3", port_write_addr); else pass_count++;
        check_count++; if (port_write_data !== 32'hDEADBEEF) $display("FAIL alu_only_data: got %h want deadbeef", port_write_data); else pass_count++;
        step();
        #4;
        check_count++; if (port_write_enable !== 1'b0) $display("FAIL alu_only_single_pulse: got %b want 0", port_write_enable); else pass_count++;
        $display("txn alu_only: r3 <= deadbeef");
    endtask

    task automatic test_conflict();
        step();
        alu_valid = 1'b1; alu_write = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h22;
        #4;
        check_count++; if ({alu_ready, mem_ready} !== 2'b01) $display("FAIL conflict1_ready: got %b want 01", {alu_ready, mem_ready}); else pass_count++;
        step();
        mem_valid = 1'b0;
        #4;
        check_count++; if ({port_write_enable, port_write_addr, port_write_data} !== {1'b1, 4'd2, 32'h22}) $display("FAIL conflict1_write_r2: got %b/%0d/%h want 1/2/22", port_write_enable, port_write_addr, port_write_data); else pass_count++;
        check_count++; if (alu_ready !== 1'b1) $display("FAIL conflict1_alu_later: got %b want 1", alu_ready); else pass_count++;
        step();
        alu_valid = 1'b0;
        #4;
        check_count++; if ({port_write_enable, port_write_addr, port_write_data} !== {1'b1, 4'd1, 32'h11}) $display("FAIL conflict1_write_r1: got %b/%0d/%h want 1/1/11", port_write_enable, port_write_addr, port_write_data); else pass_count++;
        $display("txn conflict: mem r2 then alu r1");
        step();
        alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 32'h44;
        mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 32'h66;
        #4;
        check_count++; if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL conflict2_ready: got %b want 10", {alu_ready, mem_ready}); else pass_count++;
        step();
        alu_valid = 1'b0;
        #4;
        check_count++; if ({port_write_enable, port_write_addr, port_write_data} !== {1'b1, 4'd4, 32'h44}) $display("FAIL conflict2_write_r4: got %b/%0d/%h want 1/4/44", port_write_enable, port_write_addr, port_write_data); else pass_count++;
        check_count++; if (mem_ready !== 1'b1) $display("FAIL conflict2_mem_later: got %b want 1", mem_ready); else pass_count++;
        step();
        mem_valid = 1'b0;
        #4;
        check_count++; if ({port_write_enable, port_write_addr, port_write_data} !== {1'b1, 4'd6, 32'h66}) $display("FAIL conflict2_write_r6: got %b/%0d/%h want 1/6/66", port_write_enable, port_write_addr, port_write_data); else pass_count++;
        $display("txn conflict: alu r4 then mem r6 (round robin)");
    endtask

    task automatic test_no_dest();
        step();
        alu_valid = 1'b1; alu_write = 1'b0; alu_addr = 4'd9; alu_data = 32'h99;
        #4;
        check_count++; if (alu_ready !== 1'b1) $display("FAIL no_dest_ready: got %b want 1", alu_ready); else pass_count++;
        step();
        alu_valid = 1'b0;
        #4;
        check_count++; if (port_write_enable !== 1'b0) $display("FAIL no_dest_we: got %b want 0", port_write_enable); else pass_count++;
        $display("txn no_dest: alu result consumed without write");
    endtask

    task automatic test_scoreboard();
        step();
        issue_valid = 1'b1; issue_mem = 1'b0; issue_addr = 4'd5;
        step();
        issue_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0020) $display("FAIL sb_set_r5: got %h want 0020", reg_pending); else pass_count++;
        step();
        alu_valid = 1'b1; alu_write = 1'b1; alu_addr = 4'd5; alu_data = 32'h55;
        #4;
        check_count++; if (reg_pending !== 16'h0020) $display("FAIL sb_hold_r5: got %h want 0020", reg_pending); else pass_count++;
        step();
        alu_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0000) $display("FAIL sb_clear_r5: got %h want 0000", reg_pending); else pass_count++;
        check_count++; if ({port_write_enable, port_write_addr} !== {1'b1, 4'd5}) $display("FAIL sb_write_r5: got %b/%0d want 1/5", port_write_enable, port_write_addr); else pass_count++;
        $display("txn scoreboard: r5 issued then retired");
        step();
        issue_valid = 1'b1; issue_mem = 1'b0; issue_addr = 4'd5;
        step();
        alu_valid = 1'b1; alu_write = 1'b1; alu_addr = 4'd5; alu_data = 32'h56;
        step();
        issue_valid = 1'b0; alu_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0020) $display("FAIL sb_set_wins: got %h want 0020", reg_pending); else pass_count++;
        check_count++; if ({port_write_enable, port_write_data} !== {1'b1, 32'h56}) $display("FAIL sb_set_wins_write: got %b/%h want 1/56", port_write_enable, port_write_data); else pass_count++;
        step();
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h57;
        step();
        alu_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0000) $display("FAIL sb_reclear_r5: got %h want 0000", reg_pending); else pass_count++;
        $display("txn scoreboard: same-cycle issue keeps r5 pending");
        step();
        issue_valid = 1'b1; issue_mem = 1'b1; issue_addr = 4'd9;
        step();
        issue_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0200) $display("FAIL sb_set_r9_mem: got %h want 0200", reg_pending); else pass_count++;
        step();
        mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h99;
        step();
        mem_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0000) $display("FAIL sb_clear_r9_mem: got %h want 0000", reg_pending); else pass_count++;
        $display("txn scoreboard: load r9 issued then retired");
    endtask

    task automatic test_flush();
        step();
        issue_valid = 1'b1; issue_mem = 1'b0; issue_addr = 4'd1;
        step();
        issue_mem = 1'b1; issue_addr = 4'd2;
        step();
        issue_valid = 1'b0;
        #4;
        check_count++; if (reg_pending !== 16'h0006) $display("FAIL flush_pre_pending: got %h want 0006", reg_pending); else pass_count++;
        step();
        flush = 1'b1;
        alu_valid = 1'b1; alu_write = 1'b1; alu_addr = 4'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'hB2;
        issue_valid = 1'b1; issue_mem = 1'b0; issue_addr = 4'd3;
        #4;
        check_count++; if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL flush_ready: got %b want 11", {alu_ready, mem_ready}); else pass_count++;
        step();
        idle_inputs();
        #4;
        check_count++; if ({port_write_enable, port_write_addr, port_write_data} !== {1'b1, 4'd2, 32'hB2}) $display("FAIL flush_mem_write: got %b/%0d/%h want 1/2/b2", port_write_enable, port_write_addr, port_write_data); else pass_count++;
        check_count++; if (reg_pending !== 16'h0000) $display("FAIL flush_pending: got %h want 0000", reg_pending); else pass_count++;
        step();
        #4;
        check_count++; if (port_write_enable !== 1'b0) $display("FAIL flush_no_alu_write: got %b want 0", port_write_enable); else pass_count++;
        $display("txn flush: alu r1 dropped, mem r2 written");
    endtask

    task automatic test_async_reset();
        step();
        issue_valid = 1'b1; issue_mem = 1'b0; issue_addr = 4'd8;
        alu_valid = 1'b1; alu_write = 1'b1; alu_addr = 4'd7; alu_data = 32'h77;
        step();
        idle_inputs();
        check_count++; if ({port_write_enable, reg_pending} !== {1'b1, 16'h0100}) $display("FAIL areset_pre: got %b/%h want 1/0100", port_write_enable, reg_pending); else pass_count++;
        #1;
        reset_n = 1'b0;
        #1;
        check_count++; if (port_write_enable !== 1'b0) $display("FAIL areset_we: got %b want 0", port_write_enable); else pass_count++;
        check_count++; if (reg_pending !== 16'h0000) $display("FAIL areset_pending: got %h want 0000", reg_pending); else pass_count++;
        step();
        #4;
        check_count++; if ({port_write_enable, reg_pending} !== {1'b0, 16'h0000}) $display("FAIL areset_held: got %b/%h want 0/0000", port_write_enable, reg_pending); else pass_count++;
        step();
        reset_n = 1'b1;
        $display("txn async_reset: pulse cancelled mid-cycle");
    endtask

`ifdef W0RM_WB_FORWARD_EN
    task automatic test_forward();
        step();
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h5A;
        #4;
        check_count++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 4'd7, 32'h5A}) $display("FAIL fwd_mem: got %b/%0d/%h want 1/7/5a", fwd_valid, fwd_addr, fwd_data); else pass_count++;
        step();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_write = 1'b0; alu_addr = 4'd4; alu_data = 32'h44;
        #4;
        check_count++; if (fwd_valid !== 1'b0) $display("FAIL fwd_no_dest: got %b want 0", fwd_valid); else pass_count++;
        step();
        alu_write = 1'b1;
        #4;
        check_count++; if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 4'd4, 32'h44}) $display("FAIL fwd_alu: got %b/%0d/%h want 1/4/44", fwd_valid, fwd_addr, fwd_data); else pass_count++;
        step();
        idle_inputs();
        $display("txn forward: bypass of mem r7 and alu r4");
    endtask
`endif

    initial begin
        test_reset();
        test_alu_only();
        test_conflict();
        test_no_dest();
        test_scoreboard();
        test_flush();
        test_async_reset();
`ifdef W0RM_WB_FORWARD_EN
        test_forward();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
